// File: rtl/frame_swap_if.sv
// Control/status bundle between the AXI-lite register space, display driver and the swap scheduler.
interface frame_swap_if #(
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  parameter int unsigned DIV_WIDTH       = 8
) ();
  logic                       ctrl_en;
  logic                       swap_req;
  logic                       auto_swap;
  logic [DIV_WIDTH-1:0]       auto_div;
  logic                       frame_end;
  logic                       wr_busy;
  logic                       irq_ack;
  logic                       rd_buffer;
  logic                       wr_buffer;
  logic                       swap_pending;
  logic                       swap_done;
  logic                       swap_overrun;
  logic [FRAME_CNT_WIDTH-1:0] frame_count;
  logic                       irq;

  modport master (
    output ctrl_en, swap_req, auto_swap, auto_div, frame_end, wr_busy, irq_ack,
    input  rd_buffer, wr_buffer, swap_pending, swap_done, swap_overrun, frame_count, irq
  );

  modport slave (
    input  ctrl_en, swap_req, auto_swap, auto_div, frame_end, wr_busy, irq_ack,
    output rd_buffer, wr_buffer, swap_pending, swap_done, swap_overrun, frame_count, irq
  );
endinterface

// File: rtl/frame_swap_ctrl.sv
// Double-buffer swap scheduler: swaps display/write buffers only on an idle-bus frame boundary,
// on software request or every auto_div+1 frames, and reports status and a level irq.
module frame_swap_ctrl #(
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  parameter int unsigned DIV_WIDTH       = 8
) (
  input  logic          clk,
  input  logic          aresetn,
  frame_swap_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [DIV_WIDTH-1:0]       r_div_cnt;
  logic [DIV_WIDTH-1:0]       w_div_cnt_next;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
  logic [FRAME_CNT_WIDTH-1:0] w_frame_count_next;
  logic                       r_rd_buffer;
  logic                       w_rd_buffer_next;
  logic                       r_wr_buffer;
  logic                       r_swap_pending;
  logic                       r_swap_done;
  logic                       w_swap_done_next;
  logic                       r_swap_overrun;
  logic                       w_swap_overrun_next;
  logic                       r_irq;
  logic                       w_irq_next;
  logic                       w_auto_trig;
  logic                       w_trig;
  logic                       w_eligible;
  logic                       w_overrun_set;

  // Trigger decode: auto trigger fires on the frame_end that matches the divider.
  always_comb begin
    w_auto_trig   = bus.auto_swap & bus.frame_end & (r_div_cnt == bus.auto_div);
    w_trig        = bus.swap_req | w_auto_trig;
    w_eligible    = bus.frame_end & ~bus.wr_busy;
    w_overrun_set = (r_state == ST_ARMED) & w_trig;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_next        = r_state;
    w_div_cnt_next      = r_div_cnt;
    w_frame_count_next  = r_frame_count;
    w_swap_overrun_next = r_swap_overrun;
    // The swap itself already happened, so its irq is never lost; only the ack is gated.
    w_irq_next          = r_swap_done | (r_irq & ~(bus.ctrl_en & bus.irq_ack));

    if (!bus.ctrl_en) begin
      w_state_next   = ST_IDLE;
      w_div_cnt_next = '0;
    end else begin
      unique case (r_state)
        ST_IDLE:  w_state_next = w_trig ? ST_ARMED : ST_IDLE;
        ST_ARMED: w_state_next = w_eligible ? ST_SWAP : ST_ARMED;
        ST_SWAP:  w_state_next = w_trig ? ST_ARMED : ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase

      w_swap_overrun_next = w_overrun_set | (r_swap_overrun & ~bus.irq_ack);

      if (bus.frame_end) begin
        w_frame_count_next = r_frame_count + FRAME_CNT_WIDTH'(1);
      end

      if (!bus.auto_swap) begin
        w_div_cnt_next = '0;
      end else if (bus.frame_end) begin
        w_div_cnt_next = w_auto_trig ? '0 : r_div_cnt + DIV_WIDTH'(1);
      end
    end

    w_swap_done_next = (w_state_next == ST_SWAP);
    w_rd_buffer_next = r_rd_buffer ^ w_swap_done_next;
  end

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_div_cnt      <= '0;
      r_frame_count  <= '0;
      r_rd_buffer    <= 1'b0;
      r_wr_buffer    <= 1'b1;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
      r_swap_overrun <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      r_div_cnt      <= w_div_cnt_next;
      r_frame_count  <= w_frame_count_next;
      r_rd_buffer    <= w_rd_buffer_next;
      r_wr_buffer    <= ~w_rd_buffer_next;
      r_swap_pending <= (w_state_next == ST_ARMED);
      r_swap_done    <= w_swap_done_next;
      r_swap_overrun <= w_swap_overrun_next;
      r_irq          <= w_irq_next;
    end
  end

  assign bus.rd_buffer    = r_rd_buffer;
  assign bus.wr_buffer    = r_wr_buffer;
  assign bus.swap_pending = r_swap_pending;
  assign bus.swap_done    = r_swap_done;
  assign bus.swap_overrun = r_swap_overrun;
  assign bus.frame_count  = r_frame_count;
  assign bus.irq          = r_irq;

endmodule
